distribute_seq: RTL and testbench

- Sequencer for a DISTRIBUTE_IN/DISTRIBUTE_OUT instance.
- Accepts one layer command: mode, iterations and reads per iteration.
- Issues the configure pulse and held configuration fields, then monitors the distributor's output handshakes on every lane.
- Reports per-iteration progress and end of layer to the upstream layer controller.

---
 rtl/distribute_pkg.sv | 21 ++
 rtl/distribute_lane_cnt.sv | 42 ++++
 rtl/distribute_seq.sv | 130 +++++++++++++
 tb/tb_distribute_seq.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/distribute_pkg.sv
// Shared types and helpers for the distributor sequencer: FSM states, default
// widths and the per-lane handshake qualifier.
package distribute_pkg;

    localparam int DEF_NUM_DATA_OUTPUTS       = 8;
    localparam int DEF_LOG_MAX_ITERS          = 16;
    localparam int DEF_LOG_MAX_READS_PER_ITER = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONF = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A lane handshake only counts while the sequencer is collecting an iteration.
    function automatic logic lane_fire(input logic valid, input logic avail, input logic counting);
        return valid & avail & counting;
    endfunction

endpackage

// File: rtl/distribute_lane_cnt.sv
// One distributor lane: counts handshakes within an iteration and flags
// completion or handshakes that arrive after completion.
module distribute_lane_cnt
    import distribute_pkg::*;
#(
    parameter int CNT_W = DEF_LOG_MAX_READS_PER_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fire,
    input  logic [CNT_W-1:0] last_count,
    output logic             lane_done,
    output logic             finishing,
    output logic             overrun
);

    logic [CNT_W-1:0] count_r;
    logic             lane_done_r;

    // Handshake counter and done flag; clear wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= '0;
            lane_done_r <= 1'b0;
        end else if (clear) begin
            count_r     <= '0;
            lane_done_r <= 1'b0;
        end else if (fire && !lane_done_r) begin
            if (count_r == last_count) begin
                lane_done_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign lane_done = lane_done_r;
    assign finishing = fire & ~lane_done_r & (count_r == last_count);
    assign overrun   = fire & lane_done_r;

endmodule

// File: rtl/distribute_seq.sv
// Layer sequencer for a DISTRIBUTE_IN/DISTRIBUTE_OUT pair: accepts a command,
// configures the distributor and tracks per-lane handshakes per iteration.
module distribute_seq
    import distribute_pkg::*;
#(
    parameter int NUM_DATA_OUTPUTS       = DEF_NUM_DATA_OUTPUTS,
    parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_mode,
    input  logic [LOG_MAX_ITERS-1:0]          cmd_num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] cmd_num_reads,
    output logic                              configure,
    output logic                              conf_mode,
    output logic [LOG_MAX_ITERS-1:0]          num_iters,
    output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [NUM_DATA_OUTPUTS-1:0]       mon_valid,
    input  logic [NUM_DATA_OUTPUTS-1:0]       mon_avail,
    output logic                              busy,
    output logic [LOG_MAX_ITERS-1:0]          cur_iter,
    output logic                              iter_done,
    output logic                              done,
    output logic                              overrun_err
);

    state_e                              state_r;
    logic [NUM_DATA_OUTPUTS-1:0]         fire_s;
    logic [NUM_DATA_OUTPUTS-1:0]         lane_done_s;
    logic [NUM_DATA_OUTPUTS-1:0]         finishing_s;
    logic [NUM_DATA_OUTPUTS-1:0]         overrun_s;
    logic [LOG_MAX_READS_PER_ITER-1:0]   last_count_s;
    logic                                in_run_s;
    logic                                all_done_s;
    logic                                clear_s;

    assign in_run_s     = (state_r == ST_RUN);
    assign last_count_s = num_reads_per_iter - LOG_MAX_READS_PER_ITER'(1);
    // Lanes finishing this very cycle already count toward closing the iteration.
    assign all_done_s   = &(lane_done_s | finishing_s);
    assign clear_s      = ~in_run_s | all_done_s;

    for (genvar i = 0; i < NUM_DATA_OUTPUTS; i++) begin : g_lane
        assign fire_s[i] = lane_fire(mon_valid[i], mon_avail[i], in_run_s);

        distribute_lane_cnt #(
            .CNT_W(LOG_MAX_READS_PER_ITER)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear_s),
            .fire       (fire_s[i]),
            .last_count (last_count_s),
            .lane_done  (lane_done_s[i]),
            .finishing  (finishing_s[i]),
            .overrun    (overrun_s[i])
        );
    end

    // Sequencer FSM with all handshake-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            cmd_ready          <= 1'b1;
            configure          <= 1'b0;
            conf_mode          <= 1'b0;
            num_iters          <= '0;
            num_reads_per_iter <= '0;
            busy               <= 1'b0;
            cur_iter           <= '0;
            iter_done          <= 1'b0;
            done               <= 1'b0;
            overrun_err        <= 1'b0;
        end else begin
            configure <= 1'b0;
            iter_done <= 1'b0;
            done      <= 1'b0;
            if (|overrun_s) begin
                overrun_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        conf_mode          <= cmd_mode;
                        num_iters          <= cmd_num_iters;
                        num_reads_per_iter <= cmd_num_reads;
                        configure          <= 1'b1;
                        cur_iter           <= '0;
                        busy               <= 1'b1;
                        cmd_ready          <= 1'b0;
                        state_r            <= ST_CONF;
                    end
                end
                ST_CONF: begin
                    if ((num_iters == '0) || (num_reads_per_iter == '0)) begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (all_done_s) begin
                        iter_done <= 1'b1;
                        if (cur_iter == num_iters - LOG_MAX_ITERS'(1)) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            cur_iter <= cur_iter + LOG_MAX_ITERS'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distribute_seq.sv
// Self-checking bench for distribute_seq: directed layers plus randomized lane
// traffic compared against a per-lane counting model of the layer.
module tb_distribute_seq;

    localparam int N      = 8;
    localparam int LI     = 16;
    localparam int LR     = 16;
    localparam int HS_LEN = 200;
    localparam int MAXC   = HS_LEN + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [LI-1:0] cmd_num_iters;
    logic [LR-1:0] cmd_num_reads;
    logic          configure;
    logic          conf_mode;
    logic [LI-1:0] num_iters;
    logic [LR-1:0] num_reads_per_iter;
    logic [N-1:0]  mon_valid;
    logic [N-1:0]  mon_avail;
    logic          busy;
    logic [LI-1:0] cur_iter;
    logic          iter_done;
    logic          done;
    logic          overrun_err;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] hs [HS_LEN];
    bit           exp_id [MAXC];
    int           exp_ci [MAXC];

    bit            ovr_prev;
    logic          held_mode_prev;
    logic [LI-1:0] held_iters_prev;
    logic [LR-1:0] held_reads_prev;

    int obs_done_c;
    int obs_id_cnt;
    int obs_first_id_c;
    int obs_first_ovr_c;

    always #5 clk = ~clk;

    distribute_seq #(
        .NUM_DATA_OUTPUTS       (N),
        .LOG_MAX_ITERS          (LI),
        .LOG_MAX_READS_PER_ITER (LR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_mode           (cmd_mode),
        .cmd_num_iters      (cmd_num_iters),
        .cmd_num_reads      (cmd_num_reads),
        .configure          (configure),
        .conf_mode          (conf_mode),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .mon_valid          (mon_valid),
        .mon_avail          (mon_avail),
        .busy               (busy),
        .cur_iter           (cur_iter),
        .iter_done          (iter_done),
        .done               (done),
        .overrun_err        (overrun_err)
    );

    // A set bit fires the lane; a clear bit shows a random non-handshake pattern.
    task automatic drive_lanes(input logic [N-1:0] v);
        int r;
        for (int l = 0; l < N; l++) begin
            if (v[l]) begin
                mon_valid[l] = 1'b1;
                mon_avail[l] = 1'b1;
            end else begin
                r = int'($urandom_range(0, 2));
                mon_valid[l] = (r == 1);
                mon_avail[l] = (r == 2);
            end
        end
    endtask

    task automatic fill_hs_zero();
        for (int t = 0; t < HS_LEN; t++) hs[t] = '0;
    endtask

    task automatic fill_hs_ones();
        for (int t = 0; t < HS_LEN; t++) hs[t] = '1;
    endtask

    task automatic fill_hs_random();
        for (int t = 0; t < HS_LEN; t++) begin
            if (t < 150) hs[t] = N'($urandom | $urandom);
            else         hs[t] = '1;
        end
    endtask

    task automatic do_reset(input int ncyc);
        logic [55:0] obs;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            rst           = 1'b1;
            cmd_valid     = 1'($urandom);
            cmd_mode      = 1'($urandom);
            cmd_num_iters = LI'($urandom);
            cmd_num_reads = LR'($urandom);
            drive_lanes(N'($urandom));
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        mon_valid = '0;
        mon_avail = '0;
        @(negedge clk);
        obs = {1'b0, cmd_ready, configure, busy, done, iter_done, overrun_err, conf_mode,
               num_iters, num_reads_per_iter, cur_iter};
        checks++;
        if (obs !== {1'b0, 1'b1, 54'd0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs, {1'b0, 1'b1, 54'd0});
        end
        ovr_prev        = 1'b0;
        held_mode_prev  = 1'b0;
        held_iters_prev = '0;
        held_reads_prev = '0;
    endtask

    // Runs one layer accepted in the first cycle, checking every cycle through DONE.
    task automatic run_layer(input string name, input logic mode, input int iters,
                             input int reads, input bit keep_valid);
        int cnt [N];
        int t, c, dd, completed, ov_at;
        bit all_met, eov;
        for (int k = 0; k < MAXC; k++) begin
            exp_id[k] = 1'b0;
            exp_ci[k] = 0;
        end
        ov_at = -1;
        completed = 0;
        t = 0;
        if (iters == 0 || reads == 0) begin
            dd = 2;
        end else begin
            for (int l = 0; l < N; l++) cnt[l] = 0;
            while (completed < iters && t < HS_LEN) begin
                c = t + 2;
                exp_ci[c] = completed;
                for (int l = 0; l < N; l++) begin
                    if (hs[t][l]) begin
                        if (cnt[l] >= reads) begin
                            if (ov_at < 0) ov_at = c + 1;
                        end else begin
                            cnt[l]++;
                        end
                    end
                end
                all_met = 1'b1;
                for (int l = 0; l < N; l++) if (cnt[l] < reads) all_met = 1'b0;
                if (all_met) begin
                    exp_id[c + 1] = 1'b1;
                    completed++;
                    for (int l = 0; l < N; l++) cnt[l] = 0;
                end
                t++;
            end
            dd = t + 2;
            exp_ci[dd] = iters - 1;
            if (completed < iters) begin
                checks++;
                failures++;
                $display("FAIL %s stimulus_budget completed=%0d want=%0d", name, completed, iters);
            end
        end

        obs_done_c = -1;
        obs_id_cnt = 0;
        obs_first_id_c = -1;
        obs_first_ovr_c = -1;
        eov = ovr_prev;
        for (int cc = 0; cc <= dd; cc++) begin
            @(posedge clk); #1;
            if (cc == 0) begin
                cmd_valid     = 1'b1;
                cmd_mode      = mode;
                cmd_num_iters = LI'(iters);
                cmd_num_reads = LR'(reads);
                drive_lanes(N'($urandom));
            end else begin
                cmd_valid     = keep_valid;
                cmd_mode      = 1'($urandom);
                cmd_num_iters = LI'($urandom);
                cmd_num_reads = LR'($urandom);
                if (cc >= 2) drive_lanes(hs[cc - 2]);
                else         drive_lanes(N'($urandom));
            end
            @(negedge clk);
            eov = ovr_prev || (ov_at >= 0 && cc >= ov_at);
            if (done === 1'b1 && obs_done_c < 0) obs_done_c = cc;
            if (iter_done === 1'b1) begin
                obs_id_cnt++;
                if (obs_first_id_c < 0) obs_first_id_c = cc;
            end
            if (overrun_err === 1'b1 && obs_first_ovr_c < 0) obs_first_ovr_c = cc;

            checks++;
            if (cmd_ready !== (cc == 0)) begin
                failures++;
                $display("FAIL %s cmd_ready c=%0d got=%b want=%b", name, cc, cmd_ready, cc == 0);
            end
            checks++;
            if (configure !== (cc == 1)) begin
                failures++;
                $display("FAIL %s configure c=%0d got=%b want=%b", name, cc, configure, cc == 1);
            end
            checks++;
            if (busy !== (cc != 0)) begin
                failures++;
                $display("FAIL %s busy c=%0d got=%b want=%b", name, cc, busy, cc != 0);
            end
            checks++;
            if (done !== (cc == dd)) begin
                failures++;
                $display("FAIL %s done c=%0d got=%b want=%b", name, cc, done, cc == dd);
            end
            checks++;
            if (iter_done !== exp_id[cc]) begin
                failures++;
                $display("FAIL %s iter_done c=%0d got=%b want=%b", name, cc, iter_done, exp_id[cc]);
            end
            checks++;
            if (overrun_err !== eov) begin
                failures++;
                $display("FAIL %s overrun_err c=%0d got=%b want=%b", name, cc, overrun_err, eov);
            end
            if (cc >= 1) begin
                checks++;
                if (cur_iter !== LI'(exp_ci[cc])) begin
                    failures++;
                    $display("FAIL %s cur_iter c=%0d got=%0d want=%0d", name, cc, cur_iter, exp_ci[cc]);
                end
                checks++;
                if ({conf_mode, num_iters, num_reads_per_iter} !== {mode, LI'(iters), LR'(reads)}) begin
                    failures++;
                    $display("FAIL %s held_fields c=%0d got=%b/%0d/%0d want=%b/%0d/%0d", name, cc,
                             conf_mode, num_iters, num_reads_per_iter, mode, iters, reads);
                end
            end else begin
                checks++;
                if ({conf_mode, num_iters, num_reads_per_iter} !==
                    {held_mode_prev, held_iters_prev, held_reads_prev}) begin
                    failures++;
                    $display("FAIL %s held_before_accept got=%b/%0d/%0d want=%b/%0d/%0d", name,
                             conf_mode, num_iters, num_reads_per_iter,
                             held_mode_prev, held_iters_prev, held_reads_prev);
                end
            end
        end
        ovr_prev        = eov;
        held_mode_prev  = mode;
        held_iters_prev = LI'(iters);
        held_reads_prev = LR'(reads);
    endtask

    task automatic idle_ready_check(input string name);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mon_valid = '0;
        mon_avail = '0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_after_done got=%b/%b want=1/0", name, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_two_iters_all_fire();
        fill_hs_ones();
        run_layer("two_iters", 1'b1, 2, 3, 1'b0);
        checks++;
        if (obs_first_id_c !== 5 || obs_id_cnt !== 2 || obs_done_c !== 8) begin
            failures++;
            $display("FAIL two_iters timing got=first_id %0d ids %0d done %0d want=5 2 8",
                     obs_first_id_c, obs_id_cnt, obs_done_c);
        end
        idle_ready_check("two_iters");
    endtask

    task automatic test_lagging_lane();
        do_reset(1);
        fill_hs_zero();
        for (int t = 0; t < 4; t++) hs[t] = 8'h7F;
        for (int t = 5; t < 9; t++) hs[t] = 8'h80;
        run_layer("lagging_lane", 1'b0, 1, 4, 1'b0);
        checks++;
        if (obs_first_id_c !== 11 || obs_done_c !== 11 || obs_first_ovr_c !== -1) begin
            failures++;
            $display("FAIL lagging_lane timing got=id %0d done %0d ovr %0d want=11 11 -1",
                     obs_first_id_c, obs_done_c, obs_first_ovr_c);
        end
    endtask

    task automatic test_overrun();
        do_reset(1);
        fill_hs_zero();
        for (int t = 0; t < 3; t++) hs[t] = 8'h01;
        hs[3] = 8'hFE;
        hs[4] = 8'hFE;
        run_layer("overrun", 1'b1, 1, 2, 1'b0);
        checks++;
        if (obs_first_ovr_c !== 5 || obs_done_c !== 7) begin
            failures++;
            $display("FAIL overrun timing got=ovr %0d done %0d want=5 7", obs_first_ovr_c, obs_done_c);
        end
        idle_ready_check("overrun");
        checks++;
        if (overrun_err !== 1'b1) begin
            failures++;
            $display("FAIL overrun sticky_after_done got=%b want=1", overrun_err);
        end
    endtask

    task automatic test_zero_iters();
        do_reset(1);
        fill_hs_ones();
        run_layer("zero_iters", 1'b0, 0, 5, 1'b0);
        checks++;
        if (obs_done_c !== 2 || obs_id_cnt !== 0) begin
            failures++;
            $display("FAIL zero_iters timing got=done %0d ids %0d want=2 0", obs_done_c, obs_id_cnt);
        end
        fill_hs_ones();
        run_layer("zero_reads", 1'b1, 3, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [55:0] obs;
        do_reset(1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_num_iters = 16'd3; cmd_num_reads = 16'd2;
        mon_valid = '0; mon_avail = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            mon_valid = '1; mon_avail = '1;
        end
        @(negedge clk);
        checks++;
        if (cur_iter !== 16'd1 || iter_done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_run progress got=%0d/%b/%b want=1/1/1", cur_iter, iter_done, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_run before_reset got=%b/%b want=1/0", busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0; mon_valid = '0; mon_avail = '0;
        @(negedge clk);
        obs = {1'b0, cmd_ready, configure, busy, done, iter_done, overrun_err, conf_mode,
               num_iters, num_reads_per_iter, cur_iter};
        checks++;
        if (obs !== {1'b0, 1'b1, 54'd0}) begin
            failures++;
            $display("FAIL mid_run after_reset got=%h want=%h", obs, {1'b0, 1'b1, 54'd0});
        end
        ovr_prev = 1'b0; held_mode_prev = 1'b0; held_iters_prev = '0; held_reads_prev = '0;
        fill_hs_ones();
        run_layer("after_abort", 1'b0, 2, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            fill_hs_random();
            run_layer("back_to_back", 1'($urandom), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 4)), 1'b1);
        end
        fill_hs_ones();
        run_layer("back_to_back_last", 1'b0, 1, 2, 1'b0);
        idle_ready_check("back_to_back");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            do_reset(1);
            fill_hs_random();
            run_layer("random", 1'($urandom), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 5)), 1'b0);
        end
    endtask

    // Test sequence and summary.
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0;
        cmd_num_iters = '0; cmd_num_reads = '0;
        mon_valid = '0; mon_avail = '0;
        test_reset();
        test_two_iters_all_fire();
        test_lagging_lane();
        test_overrun();
        test_zero_iters();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
